// File: rtl/jt89_wr_arb_if.sv
// Dual-requester write bus for the JT89 write arbiter.
// Master drives strobes/bytes, slave returns ready.
interface jt89_wr_arb_if;
   logic       a_wr;
   logic [7:0] a_din;
   logic       a_ready;
   logic       b_wr;
   logic [7:0] b_din;
   logic       b_ready;

   modport master (
      output a_wr, a_din, b_wr, b_din,
      input  a_ready, b_ready
   );

   modport slave (
      input  a_wr, a_din, b_wr, b_din,
      output a_ready, b_ready
   );
endinterface

// File: rtl/jt89_wr_arb.sv
// JT89 write-port arbiter and PSG register decoder.
// JT89_WRBUSY_EN enables the post-write busy window.
module jt89_wr_arb #(
   parameter int BUSY_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   jt89_wr_arb_if.slave bus,
   output logic [9:0] tone0,
   output logic [9:0] tone1,
   output logic [9:0] tone2,
   output logic [3:0] vol0,
   output logic [3:0] vol1,
   output logic [3:0] vol2,
   output logic [3:0] vol3,
   output logic [2:0] ctrl3,
   output logic       noise_rst
);

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      WAIT
   } st_t;

   st_t             st;
   logic            pend_a, pend_b;
   logic [7:0]      a_byte, b_byte;
   logic [7:0]      byte_r;
   logic            gnt_b, last_b;
   logic [1:0]      lch;
   logic            ltype;
   logic [3:0][3:0] vol_r;

   logic            is_lat, d_vol, g_b;
   logic [1:0]      d_lch;
   logic [9:0]      cur, tone_nx;
   logic            rel, cap_a, cap_b;
   logic            nxt_pa, nxt_pb;

`ifdef JT89_WRBUSY_EN
   localparam int CW = $clog2(BUSY_CYCLES + 1);
   logic [CW-1:0] cnt;
`else
   logic unused_cfg;
   assign unused_cfg = clk_en ^ BUSY_CYCLES[0];
`endif

   assign vol0 = vol_r[0];
   assign vol1 = vol_r[1];
   assign vol2 = vol_r[2];
   assign vol3 = vol_r[3];

   always_comb begin
      is_lat = byte_r[7];
      d_lch  = is_lat ? byte_r[6:5] : lch;
      d_vol  = is_lat ? byte_r[4] : ltype;
      unique case (d_lch)
         2'd0:    cur = tone0;
         2'd1:    cur = tone1;
         default: cur = tone2;
      endcase
      // Latch bytes hit the low nibble, data bytes the high six bits
      tone_nx = is_lat ? {cur[9:4], byte_r[3:0]}
                       : {byte_r[5:0], cur[3:0]};
`ifdef JT89_WRBUSY_EN
      rel = (st == WAIT) && clk_en && (cnt == '0);
`else
      rel = (st == APPLY);
`endif
      cap_a  = bus.a_wr & bus.a_ready;
      cap_b  = bus.b_wr & bus.b_ready;
      nxt_pa = (pend_a & ~(rel & ~gnt_b)) | cap_a;
      nxt_pb = (pend_b & ~(rel & gnt_b)) | cap_b;
      g_b    = pend_b & (~pend_a | ~last_b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st          <= IDLE;
         pend_a      <= 1'b0;
         pend_b      <= 1'b0;
         bus.a_ready <= 1'b1;
         bus.b_ready <= 1'b1;
         a_byte      <= '0;
         b_byte      <= '0;
         byte_r      <= '0;
         gnt_b       <= 1'b0;
         last_b      <= 1'b1;
         lch         <= '0;
         ltype       <= 1'b0;
         tone0       <= '0;
         tone1       <= '0;
         tone2       <= '0;
         vol_r       <= '1;
         ctrl3       <= '0;
         noise_rst   <= 1'b0;
`ifdef JT89_WRBUSY_EN
         cnt         <= '0;
`endif
      end else begin
         pend_a      <= nxt_pa;
         pend_b      <= nxt_pb;
         bus.a_ready <= ~nxt_pa;
         bus.b_ready <= ~nxt_pb;
         noise_rst   <= 1'b0;
         if (cap_a) a_byte <= bus.a_din;
         if (cap_b) b_byte <= bus.b_din;
         case (st)
            IDLE: if (pend_a | pend_b) begin
               gnt_b  <= g_b;
               last_b <= g_b;
               byte_r <= g_b ? b_byte : a_byte;
               st     <= APPLY;
            end
            APPLY: begin
               if (is_lat) begin
                  lch   <= byte_r[6:5];
                  ltype <= byte_r[4];
               end
               if (d_vol) vol_r[d_lch] <= byte_r[3:0];
               else begin
                  unique case (d_lch)
                     2'd0: tone0 <= tone_nx;
                     2'd1: tone1 <= tone_nx;
                     2'd2: tone2 <= tone_nx;
                     2'd3: begin
                        ctrl3     <= byte_r[2:0];
                        noise_rst <= 1'b1;
                     end
                  endcase
               end
`ifdef JT89_WRBUSY_EN
               cnt <= CW'(BUSY_CYCLES - 1);
               st  <= WAIT;
`else
               st  <= IDLE;
`endif
            end
`ifdef JT89_WRBUSY_EN
            WAIT: if (clk_en) begin
               if (cnt == '0) st <= IDLE;
               else cnt <= cnt - 1'b1;
            end
`endif
            default: st <= IDLE;
         endcase
      end
   end

endmodule
